// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker: hunts for a seed in the received serial stream,
// verifies it, then flywheels its own LFSR to count bit errors and detect loss of sync.
module lfsr_prbs_checker #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
  parameter int               LOCK_COUNT  = 8,
  parameter int               LOSS_THRESH = 4,
  parameter int               ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic [1:0]           sync_state,
  output logic                 bit_error,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t         state, state_n;
  logic [WIDTH-1:0] exp, exp_n;
  logic [FW-1:0]  fill, fill_n;
  logic [MW-1:0]  match_cnt, match_n;
  logic [LW-1:0]  miss_cnt, miss_n;
  logic           err_n;
  logic           pred;

  assign pred = ^(exp & TAPS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      exp       <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      bit_error <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      exp       <= exp_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      bit_error <= err_n;
      if (clear_cnt)
        err_count <= '0;
      else if (err_n && !(&err_count))
        err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    exp_n   = exp;
    fill_n  = fill;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    err_n   = 1'b0;
    if (bit_valid) begin
      unique case (state)
        HUNT: begin
          exp_n  = {exp[WIDTH-2:0], bit_in};
          fill_n = (fill == FW'(WIDTH)) ? fill : fill + 1'b1;
          // All-zero is not a state the generator can reach, so never seed from it.
          if (fill_n == FW'(WIDTH) && exp_n != '0) begin
            state_n = VERIFY;
            match_n = '0;
          end
        end
        VERIFY: begin
          if (bit_in == pred) begin
            exp_n   = {exp[WIDTH-2:0], pred};
            match_n = match_cnt + 1'b1;
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            state_n = HUNT;
            exp_n   = '0;
            fill_n  = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the reference advances on its own prediction, ignoring bit_in.
          exp_n = {exp[WIDTH-2:0], pred};
          if (bit_in == pred) begin
            miss_n = '0;
          end else begin
            err_n  = 1'b1;
            miss_n = miss_cnt + 1'b1;
            if (miss_cnt == LW'(LOSS_THRESH - 1)) begin
              state_n = HUNT;
              exp_n   = '0;
              fill_n  = '0;
              miss_n  = '0;
            end
          end
        end
        default: begin
          state_n = HUNT;
          exp_n   = '0;
          fill_n  = '0;
        end
      endcase
    end
  end

  assign locked     = (state == LOCKED);
  assign sync_state = state;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: acquisition, flywheel, loss of sync,
// gapped strobes, counter clear and reset, on the default x^4+x^3+1 stream.
module tb_lfsr_prbs_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_valid;
  logic        bit_in;
  logic        clear_cnt;
  logic        locked;
  logic [1:0]  sync_state;
  logic        bit_error;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] g;

  lfsr_prbs_checker dut (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clear_cnt  (clear_cnt),
    .locked     (locked),
    .sync_state (sync_state),
    .bit_error  (bit_error),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference generator: new LSB = g[3]^g[2].
  task automatic gen(output logic b);
    b = g[3] ^ g[2];
    g = {g[2:0], b};
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    bit_valid = v;
    bit_in    = b;
    clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic b;
    int   vcnt;
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;

    step(0, 0, 0);
    chk("rst_locked", locked, 0);
    chk("rst_state", sync_state, 0);
    chk("rst_err", bit_error, 0);
    chk("rst_cnt", err_count, 0);
    reset = 1'b0;

    // Clean acquisition from seed 0001: VERIFY after bit 4, LOCKED after bit 12.
    g = 4'b0001;
    for (int i = 1; i <= 100; i++) begin
      gen(b);
      step(1, b, 0);
      if (i == 3)  chk("acq_hunt3", sync_state, 2'b00);
      if (i == 4)  chk("acq_verify4", sync_state, 2'b01);
      if (i == 11) chk("acq_nolock11", locked, 0);
      if (i == 12) begin
        chk("acq_lock12", locked, 1);
        chk("acq_state12", sync_state, 2'b10);
      end
      if (bit_error !== 1'b0) chk("acq_noerr", bit_error, 0);
    end
    chk("acq_cnt100", err_count, 0);

    // Single flipped bit: one pulse, flywheel keeps lock.
    for (int i = 1; i <= 30; i++) begin
      gen(b);
      step(1, (i == 20) ? ~b : b, 0);
      if (i == 20) begin
        chk("flip_pulse", bit_error, 1);
        chk("flip_cnt", err_count, 1);
        chk("flip_locked", locked, 1);
      end
      if (i == 21) chk("flip_pulse_end", bit_error, 0);
      if (i != 20 && bit_error !== 1'b0) chk("flip_noerr", bit_error, 0);
    end
    chk("flip_cnt_final", err_count, 1);
    chk("flip_locked_final", locked, 1);

    // Clear counter without touching sync.
    step(0, 0, 1);
    chk("clr_cnt", err_count, 0);
    chk("clr_locked", locked, 1);
    chk("clr_no_pulse", bit_error, 0);

    // Four inverted bits -> loss of sync, then relock after 12 clean bits.
    for (int i = 1; i <= 4; i++) begin
      gen(b);
      step(1, ~b, 0);
      chk("burst_pulse", bit_error, 1);
      if (i == 3) chk("burst_still_locked", sync_state, 2'b10);
    end
    chk("burst_hunt", sync_state, 2'b00);
    chk("burst_cnt", err_count, 4);
    for (int i = 1; i <= 12; i++) begin
      gen(b);
      step(1, b, 0);
      if (i == 1)  chk("relock_no_pulse", bit_error, 0);
      if (i == 4)  chk("relock_verify", sync_state, 2'b01);
      if (i == 11) chk("relock_nolock11", locked, 0);
      if (i == 12) chk("relock_lock12", locked, 1);
    end
    chk("relock_cnt", err_count, 4);

    // clear_cnt coincident with an error: clear wins, pulse still fires.
    gen(b);
    step(1, ~b, 1);
    chk("clrerr_pulse", bit_error, 1);
    chk("clrerr_cnt", err_count, 0);
    gen(b);
    step(1, b, 0);
    chk("clrerr_after", bit_error, 0);
    chk("clrerr_locked", locked, 1);

    // Reset while locked.
    reset = 1'b1;
    gen(b);
    step(1, b, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_state", sync_state, 0);
    chk("midrst_cnt", err_count, 0);
    reset = 1'b0;

    // All-zero input never leaves HUNT.
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0);
      if (sync_state !== 2'b00) chk("zero_hunt", sync_state, 2'b00);
    end
    chk("zero_state", sync_state, 2'b00);
    chk("zero_locked", locked, 0);
    chk("zero_cnt", err_count, 0);

    // Gapped strobe (1-0-0-1): lock point counted in valid bits only.
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    g = 4'b0001;
    vcnt = 0;
    for (int c = 0; c < 60 && vcnt < 12; c++) begin
      if ((c % 4) == 0 || (c % 4) == 3) begin
        gen(b);
        step(1, b, 0);
        vcnt++;
        if (vcnt == 3)  chk("gap_hunt3", sync_state, 2'b00);
        if (vcnt == 4)  chk("gap_verify4", sync_state, 2'b01);
        if (vcnt == 11) chk("gap_nolock11", locked, 0);
        if (vcnt == 12) chk("gap_lock12", locked, 1);
      end else begin
        step(0, 1'($urandom_range(1)), 0);
        if (bit_error !== 1'b0) chk("gap_noerr_idle", bit_error, 0);
      end
    end
    chk("gap_reached12", vcnt, 12);
    chk("gap_cnt", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
